weight_bram_loader: RTL and testbench

Streams one layer's convolution weights from the weight BRAM into the `weights_fifo` write port. It generates sequential BRAM read addresses and absorbs the BRAM's 1-cycle read latency with a 2-entry output buffer. It presents the words on a valid/ready handshake in the order the FIFO expects: channel fastest, then kernel position (row-major), then filter. It sits directly upstream of `weights_fifo` and is started once per layer by the layer controller.

---
 rtl/weight_bram_loader.sv | 129 ++++++++++++
 tb/tb_weight_bram_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_bram_loader.sv
// rtl/weight_bram_loader.sv - streams one layer's weights from BRAM into the weights FIFO write port
module weight_bram_loader #(
  parameter int DATA_WIDTH   = 16,
  parameter int IN_CHANNELS  = 4,
  parameter int OUT_CHANNELS = 4,
  parameter int KERNEL_SIZE  = 3,
  parameter int ADDR_WIDTH   = 10,
  parameter int BASE_ADDR    = 0,
  localparam int TOTAL      = OUT_CHANNELS * IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
  localparam int PER_FILTER = IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
  localparam int FW         = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         bram_en,
  output logic [ADDR_WIDTH-1:0]        bram_addr,
  input  logic signed [DATA_WIDTH-1:0] bram_dout,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic signed [DATA_WIDTH-1:0] wr_data,
  output logic                         busy,
  output logic                         done,
  output logic [FW-1:0]                filter_idx
);

  localparam int CW = $clog2(TOTAL + 1);
  localparam int PW = (PER_FILTER > 1) ? $clog2(PER_FILTER) : 1;
  localparam logic [CW-1:0] TOT      = CW'(TOTAL);
  localparam logic [CW-1:0] TOT_LAST = CW'(TOTAL - 1);
  localparam logic [PW-1:0] PF_LAST  = PW'(PER_FILTER - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t                       state, state_nx;
  logic [CW-1:0]                rd_cnt, out_cnt;
  logic [PW-1:0]                pf_cnt;
  logic [FW-1:0]                filt;
  logic [1:0]                   occ;
  logic                         inflight;
  logic signed [DATA_WIDTH-1:0] head, tail;
  logic                         pop;
  logic [2:0]                   level;

  assign pop   = wr_valid && wr_ready;
  // Occupancy the buffer will have once this cycle's pop and in-flight word settle.
  assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  always_comb begin
    state_nx = state;
    bram_en  = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD: begin
        bram_en = (rd_cnt < TOT) && (level < 3'd2);
        if (bram_en && (rd_cnt == TOT_LAST)) state_nx = S_DRAIN;
      end
      S_DRAIN: if (pop && (out_cnt == TOT_LAST)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      inflight <= 1'b0;
      rd_cnt   <= '0;
      out_cnt  <= '0;
      pf_cnt   <= '0;
      filt     <= '0;
      occ      <= 2'd0;
      head     <= '0;
      tail     <= '0;
    end else begin
      state    <= state_nx;
      inflight <= bram_en;
      if (state == S_IDLE && start) begin
        rd_cnt  <= '0;
        out_cnt <= '0;
        pf_cnt  <= '0;
        filt    <= '0;
        occ     <= 2'd0;
        head    <= '0;
        tail    <= '0;
      end else begin
        if (bram_en) rd_cnt <= rd_cnt + 1'b1;
        if (pop) begin
          out_cnt <= out_cnt + 1'b1;
          if (pf_cnt == PF_LAST) begin
            pf_cnt <= '0;
            filt   <= filt + 1'b1;
          end else begin
            pf_cnt <= pf_cnt + 1'b1;
          end
        end
        // Two-entry FIFO: head is the word on wr_data, tail the one behind it.
        case ({inflight, pop})
          2'b10: begin
            if (occ == 2'd0) head <= bram_dout;
            else             tail <= bram_dout;
            occ <= occ + 2'd1;
          end
          2'b01: begin
            head <= tail;
            occ  <= occ - 2'd1;
          end
          2'b11: begin
            if (occ == 2'd1) begin
              head <= bram_dout;
            end else begin
              head <= tail;
              tail <= bram_dout;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bram_addr  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(rd_cnt);
  assign wr_valid   = (occ != 2'd0);
  assign wr_data    = (occ != 2'd0) ? head : '0;
  assign busy       = (state == S_LOAD) || (state == S_DRAIN);
  assign done       = (state == S_DONE);
  assign filter_idx = filt;

endmodule

// File: tb/tb_weight_bram_loader.sv
// tb/tb_weight_bram_loader.sv - scoreboard bench for weight_bram_loader
module tb_weight_bram_loader;

  localparam int TOTAL = 144;
  localparam int PER_F = 36;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_ready = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic sel = 1'b0;

  logic               a_en, b_en, a_valid, b_valid, a_busy, b_busy, a_done, b_done;
  logic [9:0]         a_addr, b_addr;
  logic signed [15:0] a_dout, b_dout, a_data, b_data;
  logic [1:0]         a_fidx, b_fidx;
  logic signed [15:0] mem_a [1024];
  logic signed [15:0] mem_b [1024];

  always #5 clk = ~clk;

  weight_bram_loader #(.BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bram_en(a_en), .bram_addr(a_addr),
    .bram_dout(a_dout), .wr_valid(a_valid), .wr_ready(wr_ready), .wr_data(a_data),
    .busy(a_busy), .done(a_done), .filter_idx(a_fidx));

  weight_bram_loader #(.BASE_ADDR(512)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bram_en(b_en), .bram_addr(b_addr),
    .bram_dout(b_dout), .wr_valid(b_valid), .wr_ready(wr_ready), .wr_data(b_data),
    .busy(b_busy), .done(b_done), .filter_idx(b_fidx));

  always @(posedge clk) begin
    if (a_en) a_dout <= mem_a[a_addr];
    if (b_en) b_dout <= mem_b[b_addr];
  end

  wire               o_en    = sel ? b_en : a_en;
  wire [9:0]         o_addr  = sel ? b_addr : a_addr;
  wire               o_valid = sel ? b_valid : a_valid;
  wire signed [15:0] o_data  = sel ? b_data : a_data;
  wire               o_busy  = sel ? b_busy : a_busy;
  wire               o_done  = sel ? b_done : a_done;
  wire [1:0]         o_fidx  = sel ? b_fidx : a_fidx;

  int n_tests = 0, n_fail = 0;
  int cyc, first_valid, done_cyc, done_cnt, pops;
  int exp_q[$];
  int fid_q[$];
  logic prev_stall = 1'b0;
  logic signed [15:0] prev_data = '0;

  function automatic void chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endfunction

  task automatic tick(input logic rdy, input logic st, input logic rn);
    int e, f;
    @(posedge clk);
    #1;
    wr_ready = rdy;
    start_a  = st & ~sel;
    start_b  = st & sel;
    rst_n    = rn;
    cyc++;
    @(negedge clk);
    if (prev_stall) begin
      chk("hold_valid", 32'(o_valid), 1);
      chk("hold_data", 32'(o_data), 32'(prev_data));
    end
    if (o_valid && wr_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_word", 32'(o_data), -99999);
      end else begin
        e = exp_q.pop_front();
        f = fid_q.pop_front();
        chk("data", 32'(o_data), e);
        chk("filter_idx", {30'd0, o_fidx}, f);
        pops++;
      end
    end
    if (o_valid && first_valid < 0) first_valid = cyc;
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_in_done", 32'(o_busy), 0);
    end
    prev_stall = o_valid && !wr_ready;
    prev_data  = o_data;
  endtask

  task automatic new_run(input logic neg);
    exp_q.delete();
    fid_q.delete();
    for (int i = 0; i < TOTAL; i++) begin
      exp_q.push_back(neg ? -i : i + 1);
      fid_q.push_back(i / PER_F);
    end
    cyc = -1; first_valid = -1; done_cyc = -1; done_cnt = 0; pops = 0;
    prev_stall = 1'b0;
  endtask

  // mode 0: ready=1, 1: random ready, 2: ready=1 plus stray start pulses
  task automatic run_to_done(input int mode);
    logic st;
    for (int k = 0; k < 1000 && done_cnt == 0; k++) begin
      st = (mode == 2) && (cyc + 1 == 20 || cyc + 1 == 147);
      tick(mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1, st, 1'b1);
    end
    chk("done_seen", done_cnt, 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input int base);
    chk("rst_bram_en", 32'(o_en), 0);
    chk("rst_bram_addr", 32'(o_addr), base);
    chk("rst_wr_valid", 32'(o_valid), 0);
    chk("rst_wr_data", 32'(o_data), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_filter_idx", {30'd0, o_fidx}, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 16'(i + 1);
      mem_b[i] = 16'(512 - i);
    end
    cyc = 0;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_reset_outputs(0);
    tick(1'b0, 1'b0, 1'b1);

    // continuous ready
    new_run(1'b0);
    tick(1'b1, 1'b1, 1'b1);
    run_to_done(0);
    chk("first_valid_cycle", first_valid, 3);
    chk("done_cycle", done_cyc, TOTAL + 3);
    chk("word_count", pops, TOTAL);

    // random back-pressure
    tick(1'b0, 1'b0, 1'b1);
    new_run(1'b0);
    tick(1'($urandom_range(0, 1)), 1'b1, 1'b1);
    run_to_done(1);
    chk("rand_word_count", pops, TOTAL);

    // 20-cycle stall after first valid
    tick(1'b0, 1'b0, 1'b1);
    new_run(1'b0);
    tick(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 10 && first_valid < 0; k++) tick(1'b0, 1'b0, 1'b1);
    chk("stall_first_valid", first_valid, 3);
    chk("stall_en_at_first", 32'(o_en), 0);
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 1'b0, 1'b1);
      chk("stall_bram_en", 32'(o_en), 0);
    end
    begin
      int rel;
      rel = cyc + 1;
      run_to_done(0);
      chk("stall_resume_done", done_cyc, rel + TOTAL);
    end

    // reset after 50 words, then replay
    tick(1'b0, 1'b0, 1'b1);
    new_run(1'b0);
    tick(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 200 && pops < 50; k++) tick(1'b1, 1'b0, 1'b1);
    chk("pops_before_reset", pops, 50);
    tick(1'b1, 1'b0, 1'b0);
    exp_q.delete();
    fid_q.delete();
    prev_stall = 1'b0;
    tick(1'b1, 1'b0, 1'b1);
    check_reset_outputs(0);
    new_run(1'b0);
    tick(1'b1, 1'b1, 1'b1);
    run_to_done(0);
    chk("replay_done_cycle", done_cyc, TOTAL + 3);

    // stray start in LOAD and in DONE
    tick(1'b0, 1'b0, 1'b1);
    new_run(1'b0);
    tick(1'b1, 1'b1, 1'b1);
    run_to_done(2);
    for (int k = 0; k < 10; k++) tick(1'b1, 1'b0, 1'b1);
    chk("stray_done_count", done_cnt, 1);
    chk("stray_word_count", pops, TOTAL);
    chk("stray_busy_after", 32'(o_busy), 0);

    // signed data from BASE_ADDR=512
    tick(1'b0, 1'b0, 1'b1);
    sel = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    chk("b_idle_addr_base", 32'(o_addr), 512);
    new_run(1'b1);
    tick(1'b1, 1'b1, 1'b1);
    run_to_done(0);
    chk("b_done_cycle", done_cyc, TOTAL + 3);
    chk("b_word_count", pops, TOTAL);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
